bsg_clk_gen_osc_ds: RTL and testbench
=====================================

# bsg_clk_gen_osc_ds

Programmable clock downsampler that sits directly downstream of the clock-generator ring oscillator. It runs on the raw oscillator output and produces a divided, 50%-duty output clock. The divisor is reconfigurable at run time through a valid/ready port fed by the tag-client payload. Divisor changes take effect only at a full-period boundary, so the output never carries a runt pulse.

## Interface
- width_p, 6: width of the divisor field.
- default_ds_p, 0: divisor loaded on reset; must fit in width_p bits.
- clk_i  in  1  oscillator clock; every register in the block is on its posedge.
- reset_i  in  1  reset (synchronous, active-high).
- cfg_v_i  in  1  new divisor valid.
- cfg_ds_i  in  width_p  requested divisor value D.
- cfg_ready_o  out  1  high when no update is pending; a cfg transfer occurs when cfg_v_i & cfg_ready_o.
- clk_o  out  1  divided clock, registered; period is 2*(D+1) clk_i cycles.
- rise_o  out  1  registered one-cycle pulse, high in the first clk_i cycle in which clk_o is high.
- ds_o  out  width_p  currently active divisor.

## Operation
- State registers:
  - cnt_r (width_p): phase counter.
  - ds_r: active divisor.
  - pend_r (width_p) and pend_v_r (1): pending divisor update.
  - clk_r drives clk_o.
  - rise_r drives rise_o.
- Reset values: cnt_r=0, ds_r=default_ds_p, pend_v_r=0, clk_o=0, rise_o=0, cfg_ready_o=1, ds_o=default_ds_p.
- Counting:
  - Each cycle, if cnt_r==ds_r then cnt_r<=0 and clk_r<=~clk_r; otherwise cnt_r<=cnt_r+1.
  - Each phase therefore lasts ds_r+1 cycles.
  - The counter compare is equality only. There is no wrap beyond ds_r, and the all-ones divisor is legal (2^width_p cycles per phase).
- Config capture:
  - On cfg_v_i & cfg_ready_o: pend_r<=cfg_ds_i and pend_v_r<=1.
  - cfg_ready_o = ~pend_v_r.
  - cfg_v_i while cfg_ready_o=0 is ignored; no overwrite of the pending value.
- Update point:
  - An update applies in the terminal cycle of the high phase: cnt_r==ds_r and clk_r==1 and pend_v_r.
  - In that cycle: ds_r<=pend_r, pend_v_r<=0, cnt_r<=0, clk_r<=0.
  - The next low phase is the first phase using the new divisor.
- rise_r <= (cnt_r==ds_r) & ~clk_r, so it is high in exactly the cycle clk_o is first high.
- Divisor D=0: clk_o toggles every cycle (clk_i/2), and rise_o is high every other cycle.
- Same-value update (pend_r==ds_r): processed normally; no visible change on clk_o.
- Simultaneous capture and apply:
  - cfg_ready_o=1 implies pend_v_r=0, so a capture and an apply can never happen in the same cycle.
  - A transfer accepted in the terminal-high cycle waits one full period before it applies.

## Timing
- clk_o and rise_o are flop outputs; no combinational path from any input to any output except cfg_ready_o, which depends only on pend_v_r (registered).
- Reset:
  - reset_i sampled high forces all reset values on the next edge.
  - It overrides counting, update and capture in that same cycle, including mid-phase and mid-pending.
  - A pending update is discarded.
  - After reset deasserts, clk_o first rises after default_ds_p+1 cycles.
- Config latency:
  - Transfer at cycle t → cfg_ready_o low from t+1.
  - ds_o and the new period change at the edge after the next terminal-high cycle. Worst case is 2*(D_old+1) cycles after t+1.
  - cfg_ready_o returns high on that same edge.
- ds_o updates on the same edge at which clk_o falls to begin the first new-divisor period.

## Test plan
- Reset with default_ds_p=0, release → clk_o toggles every cycle, rise_o high on alternate cycles, cfg_ready_o=1, ds_o=0.
- Write D=3 at an arbitrary phase → cfg_ready_o low until the current high phase ends; afterwards clk_o is 4 low / 4 high, with no phase shorter than min(old,new)+1 cycles.
- Write D=5, then assert cfg_v_i with D=9 while cfg_ready_o=0 → 9 ignored; the period settles at 12 cycles and ds_o=5.
- Write D=63 (all ones, width_p=6) → period 128 cycles, with cnt_r reaching 63 and returning to 0 without overflow.
- Assert reset_i mid-high-phase with an update pending → next cycle clk_o=0, cfg_ready_o=1, ds_o=default_ds_p; the pending value is never applied.
- Write D=2 in the terminal-high cycle → not applied at that boundary; applied exactly one full old period later.

Source files
------------

// File: rtl/bsg_clk_gen_osc_ds_if.sv
// Divisor configuration channel for bsg_clk_gen_osc_ds.
// A transfer occurs on any clk_i edge where v and ready are both high.
interface bsg_clk_gen_osc_ds_if #(
    parameter int width_p = 6
);
    logic               v;
    logic [width_p-1:0] ds;
    logic               ready;

    modport master (
        output v,
        output ds,
        input  ready
    );

    modport slave (
        input  v,
        input  ds,
        output ready
    );
endinterface

// File: rtl/bsg_clk_gen_osc_ds.sv
// Programmable 50%-duty clock divider on the raw oscillator clock.
// Divisor updates are held pending and applied only at the end of a high phase, so clk_o never carries a runt pulse.
module bsg_clk_gen_osc_ds #(
    parameter int width_p      = 6,
    parameter int default_ds_p = 0
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    bsg_clk_gen_osc_ds_if.slave  cfg,
    output logic                 clk_o,
    output logic                 rise_o,
    output logic [width_p-1:0]   ds_o
);

    localparam logic [width_p-1:0] default_ds_lp = width_p'(default_ds_p);
    localparam logic [width_p-1:0] zero_lp       = {width_p{1'b0}};
    localparam logic [width_p-1:0] one_lp        = width_p'(1'b1);

    logic [width_p-1:0] cnt_q,    cnt_d;
    logic [width_p-1:0] ds_q,     ds_d;
    logic [width_p-1:0] pend_q,   pend_d;
    logic               pend_v_q, pend_v_d;
    logic               clk_q,    clk_d;
    logic               rise_q,   rise_d;

    logic               term_s;
    logic               apply_s;
    logic               capture_s;

    // Next-state logic: phase counting, pending capture and boundary-aligned divisor apply.
    always_comb begin
        cnt_d     = cnt_q;
        ds_d      = ds_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        clk_d     = clk_q;
        rise_d    = 1'b0;
        term_s    = (cnt_q == ds_q);
        // Equality compare only, so the all-ones divisor yields a full 2^width_p cycle phase.
        apply_s   = term_s & clk_q & pend_v_q;
        capture_s = cfg.v & ~pend_v_q;

        if (term_s) begin
            cnt_d = zero_lp;
            clk_d = ~clk_q;
        end else begin
            cnt_d = cnt_q + one_lp;
            clk_d = clk_q;
        end

        rise_d = term_s & ~clk_q;

        // A capture needs pend_v_q low and an apply needs it high, so they never coincide.
        if (apply_s) begin
            ds_d     = pend_q;
            pend_v_d = 1'b0;
        end else if (capture_s) begin
            pend_d   = cfg.ds;
            pend_v_d = 1'b1;
        end else begin
            pend_d   = pend_q;
            pend_v_d = pend_v_q;
        end
    end

    // State registers with synchronous reset; reset discards any pending update.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q    <= zero_lp;
            ds_q     <= default_ds_lp;
            pend_q   <= zero_lp;
            pend_v_q <= 1'b0;
            clk_q    <= 1'b0;
            rise_q   <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            ds_q     <= ds_d;
            pend_q   <= pend_d;
            pend_v_q <= pend_v_d;
            clk_q    <= clk_d;
            rise_q   <= rise_d;
        end
    end

    assign clk_o     = clk_q;
    assign rise_o    = rise_q;
    assign ds_o      = ds_q;
    assign cfg.ready = ~pend_v_q;

endmodule

// File: tb/tb_bsg_clk_gen_osc_ds.sv
// Directed bench for bsg_clk_gen_osc_ds: phase lengths, update latency and ordering, reset override.
module tb_bsg_clk_gen_osc_ds;

    logic       clk_i;
    logic       reset_i;
    logic       clk_o;
    logic       rise_o;
    logic [5:0] ds_o;

    int checks;
    int errors;

    bsg_clk_gen_osc_ds_if #(.width_p(6)) cfg_if ();

    bsg_clk_gen_osc_ds #(
        .width_p      (6),
        .default_ds_p (0)
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .cfg     (cfg_if.slave),
        .clk_o   (clk_o),
        .rise_o  (rise_o),
        .ds_o    (ds_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_i);
    endtask

    // Counts consecutive samples (including the current one) at the given level.
    task automatic run_len(input logic level, output int n);
        n = 0;
        while (clk_o == level && n < 300) begin
            n++;
            step();
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (cfg_if.ready !== 1'b1 && n < 300) begin
            n++;
            step();
        end
    endtask

    task automatic wait_rise();
        int n;
        n = 0;
        while (rise_o !== 1'b1 && n < 300) begin
            n++;
            step();
        end
        chk("rise_timeout", (n < 300), 1);
    endtask

    task automatic cfg_write(input logic [5:0] d);
        cfg_if.v  = 1'b1;
        cfg_if.ds = d;
        step();
        cfg_if.v  = 1'b0;
    endtask

    initial begin
        int n;
        checks    = 0;
        errors    = 0;
        reset_i   = 1'b1;
        cfg_if.v  = 1'b0;
        cfg_if.ds = 6'd0;

        // Reset state
        step(); step(); step();
        chk("rst_clk",   clk_o, 0);
        chk("rst_rise",  rise_o, 0);
        chk("rst_ready", cfg_if.ready, 1);
        chk("rst_ds",    ds_o, 0);

        // D=0: clk_o toggles every cycle, rise_o on alternate cycles
        reset_i = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            chk("d0_clk",  clk_o,  ((i % 2) == 0));
            chk("d0_rise", rise_o, ((i % 2) == 0));
            step();
        end
        chk("d0_ds", ds_o, 0);

        // D=3 at an arbitrary phase
        cfg_write(6'd3);
        chk("d3_ready_low", cfg_if.ready, 0);
        wait_ready(n);
        chk("d3_latency", (n >= 1 && n <= 2), 1);
        chk("d3_ds",      ds_o, 3);
        chk("d3_clk_low", clk_o, 0);
        run_len(1'b0, n); chk("d3_low0",  n, 4);
        chk("d3_rise", rise_o, 1);
        run_len(1'b1, n); chk("d3_high0", n, 4);
        run_len(1'b0, n); chk("d3_low1",  n, 4);

        // D=5 written at a rise, then D=9 offered while not ready
        cfg_write(6'd5);
        chk("d5_ready_low", cfg_if.ready, 0);
        cfg_if.v  = 1'b1;
        cfg_if.ds = 6'd9;
        step(); step();
        cfg_if.v  = 1'b0;
        wait_ready(n);
        chk("d5_latency", n, 1);
        chk("d5_ds", ds_o, 5);
        step();
        chk("d9_ignored_ready", cfg_if.ready, 1);
        wait_rise();
        run_len(1'b1, n); chk("d5_high", n, 6);
        run_len(1'b0, n); chk("d5_low",  n, 6);
        chk("d9_ignored_ds", ds_o, 5);

        // D=2 written in the terminal-high cycle: applies one full old period later
        for (int i = 0; i < 5; i++) step();
        chk("term_hi_clk", clk_o, 1);
        cfg_if.v  = 1'b1;
        cfg_if.ds = 6'd2;
        step();
        cfg_if.v  = 1'b0;
        chk("term_clk_fell", clk_o, 0);
        chk("term_ready",    cfg_if.ready, 0);
        chk("term_ds_old",   ds_o, 5);
        run_len(1'b0, n); chk("term_old_low",  n, 6);
        chk("term_ds_mid",    ds_o, 5);
        chk("term_ready_mid", cfg_if.ready, 0);
        run_len(1'b1, n); chk("term_old_high", n, 6);
        chk("term_ready_back", cfg_if.ready, 1);
        chk("term_ds_new",     ds_o, 2);
        run_len(1'b0, n); chk("d2_low",  n, 3);
        run_len(1'b1, n); chk("d2_high", n, 3);

        // D=63 all-ones divisor
        cfg_write(6'd63);
        chk("d63_ready_low", cfg_if.ready, 0);
        wait_ready(n);
        chk("d63_latency", (n >= 1 && n <= 6), 1);
        chk("d63_ds", ds_o, 63);
        run_len(1'b0, n); chk("d63_low",  n, 64);
        run_len(1'b1, n); chk("d63_high", n, 64);
        run_len(1'b0, n); chk("d63_low2", n, 64);

        // Reset mid-high-phase with an update pending
        cfg_write(6'd1);
        for (int i = 0; i < 8; i++) step();
        chk("prerst_clk",   clk_o, 1);
        chk("prerst_ready", cfg_if.ready, 0);
        chk("prerst_ds",    ds_o, 63);
        reset_i = 1'b1;
        step();
        chk("mrst_clk",   clk_o, 0);
        chk("mrst_rise",  rise_o, 0);
        chk("mrst_ready", cfg_if.ready, 1);
        chk("mrst_ds",    ds_o, 0);
        reset_i = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            chk("post_clk", clk_o, ((i % 2) == 0));
            chk("post_ds",  ds_o, 0);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
